// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register bridge.
package spi_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CMD_ADDR_W = 7;
  localparam int unsigned CMD_RD_BIT = 7;

  localparam logic [BYTE_W-1:0] STATUS_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_SEND
  } bridge_state_e;

  // Command byte layout: rw in the top bit (1 = read), register address below.
  typedef struct packed {
    logic                  rw;
    logic [CMD_ADDR_W-1:0] addr;
  } cmd_t;

endpackage

// File: rtl/spi_gap_timer.sv
// Saturating cycle counter with clear/enable; flags when LIMIT counts have elapsed.
module spi_gap_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Clk_en,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned      CNT_W   = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  // Clear wins over counting; the count parks at LIMIT until cleared.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (i_Clk_en) begin
      if (i_clr)                        cnt <= '0;
      else if (i_en && cnt != LIMIT_V)  cnt <= cnt + CNT_W'(1);
    end
  end

  assign o_expired_c = (cnt == LIMIT_V);

endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes spiSlave bytes into local register reads/writes and returns read data
// as the next TX byte. One byte per SS frame; a transaction closes on a frame gap.
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned GAP_CYC     = 1024,
  parameter logic [7:0]  STATUS_BYTE = STATUS_BYTE_DEFAULT,
  parameter int unsigned RD_LAT_MAX  = 15
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Clk_en,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_byte_ready,
  input  logic              i_spi_busy,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_ready,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_wr_en,
  output logic              o_reg_rd_en,
  input  logic [7:0]        i_reg_rdata,
  input  logic              i_reg_rvalid,
  output logic              o_err
);

  bridge_state_e     state, state_nxt;
  cmd_t              cmd_c;
  logic              busy_q;
  logic              tx_pend;
  logic [7:0]        tx_pend_byte;
  logic              gap_exp_c, lat_exp_c, gap_to_c, busy_rise_c;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        wdata_nxt;
  logic              wr_en_nxt, rd_en_nxt, err_set_c;
  logic              tx_load_c, tx_drop_c;
  logic [7:0]        tx_load_byte_c;

  assign cmd_c       = cmd_t'(i_rx_byte);
  assign gap_to_c    = gap_exp_c && !i_byte_ready && (state != ST_IDLE);
  assign busy_rise_c = i_spi_busy && !busy_q;

  spi_gap_timer #(.LIMIT(GAP_CYC)) u_gap_timer (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_Clk_en    (i_Clk_en),
    .i_clr       (i_byte_ready),
    .i_en        (!i_spi_busy),
    .o_expired_c (gap_exp_c)
  );

  spi_gap_timer #(.LIMIT(RD_LAT_MAX)) u_lat_timer (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_Clk_en    (i_Clk_en),
    .i_clr       (state != ST_RD_WAIT),
    .i_en        (state == ST_RD_WAIT),
    .o_expired_c (lat_exp_c)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)      state <= ST_IDLE;
    else if (i_Clk_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (i_byte_ready) state_nxt = cmd_c.rw ? ST_RD_REQ : ST_CMD_WR;
      ST_CMD_WR:  if (gap_to_c) state_nxt = ST_IDLE;
      ST_RD_REQ:  state_nxt = gap_to_c ? ST_IDLE : ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (gap_to_c)                       state_nxt = ST_IDLE;
        else if (i_reg_rvalid || lat_exp_c) state_nxt = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (i_byte_ready)  state_nxt = ST_RD_REQ;
        else if (gap_to_c) state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and TX-byte update requests.
  always_comb begin
    addr_nxt       = o_reg_addr;
    wdata_nxt      = o_reg_wdata;
    wr_en_nxt      = 1'b0;
    rd_en_nxt      = 1'b0;
    err_set_c      = 1'b0;
    tx_load_c      = 1'b0;
    tx_load_byte_c = o_tx_byte;
    tx_drop_c      = 1'b0;

    if (o_reg_wr_en) addr_nxt = o_reg_addr + ADDR_W'(1);

    unique case (state)
      ST_IDLE:   if (i_byte_ready) addr_nxt = cmd_c.addr[ADDR_W-1:0];
      ST_CMD_WR: begin
        if (i_byte_ready) begin
          wdata_nxt = i_rx_byte;
          wr_en_nxt = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (i_byte_ready) err_set_c = 1'b1;
        if (!gap_to_c) begin
          rd_en_nxt = 1'b1;
          tx_drop_c = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (i_byte_ready) err_set_c = 1'b1;
        if (!gap_to_c) begin
          if (i_reg_rvalid) begin
            tx_load_c      = 1'b1;
            tx_load_byte_c = i_reg_rdata;
          end else if (lat_exp_c) begin
            err_set_c      = 1'b1;
            tx_load_c      = 1'b1;
            tx_load_byte_c = 8'hFF;
          end
        end
      end
      ST_RD_SEND: if (i_byte_ready) addr_nxt = o_reg_addr + ADDR_W'(1);
      default: ;
    endcase

    if (gap_to_c) begin
      tx_load_c      = 1'b1;
      tx_load_byte_c = STATUS_BYTE;
    end

    // The master clocked out a byte we had not refreshed yet.
    if (busy_rise_c && (state == ST_RD_REQ || state == ST_RD_WAIT)) err_set_c = 1'b1;
  end

  // Register datapath; TX updates due mid-frame wait in tx_pend until busy drops.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      busy_q       <= 1'b0;
      o_reg_addr   <= '0;
      o_reg_wdata  <= '0;
      o_reg_wr_en  <= 1'b0;
      o_reg_rd_en  <= 1'b0;
      o_err        <= 1'b0;
      o_tx_byte    <= STATUS_BYTE;
      o_tx_ready   <= 1'b1;
      tx_pend      <= 1'b0;
      tx_pend_byte <= '0;
    end else if (i_Clk_en) begin
      busy_q      <= i_spi_busy;
      o_reg_addr  <= addr_nxt;
      o_reg_wdata <= wdata_nxt;
      o_reg_wr_en <= wr_en_nxt;
      o_reg_rd_en <= rd_en_nxt;
      if (err_set_c) o_err <= 1'b1;
      if (tx_drop_c) begin
        o_tx_ready <= 1'b0;
        tx_pend    <= 1'b0;
      end else if (tx_load_c) begin
        if (i_spi_busy) begin
          tx_pend      <= 1'b1;
          tx_pend_byte <= tx_load_byte_c;
        end else begin
          o_tx_byte  <= tx_load_byte_c;
          o_tx_ready <= 1'b1;
          tx_pend    <= 1'b0;
        end
      end else if (tx_pend && !i_spi_busy) begin
        o_tx_byte  <= tx_pend_byte;
        o_tx_ready <= 1'b1;
        tx_pend    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: an SPI-master model drives byte frames and
// a bus scoreboard checks every register strobe against queued expectations.
module tb_spi_reg_bridge;
  import spi_pkg::*;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned GAP_CYC    = 1024;
  localparam int unsigned RD_LAT_MAX = 15;

  logic              clk;
  logic              rst_n, clk_en;
  logic [7:0]        rx_byte;
  logic              byte_ready, spi_busy;
  logic [7:0]        tx_byte;
  logic              tx_ready;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr_en, reg_rd_en;
  logic [7:0]        reg_rdata;
  logic              reg_rvalid;
  logic              err;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] bus_q[$];
  logic        en_q;

  spi_reg_bridge #(
    .ADDR_W(ADDR_W), .GAP_CYC(GAP_CYC), .STATUS_BYTE(8'hA5), .RD_LAT_MAX(RD_LAT_MAX)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clk_en(clk_en),
    .i_rx_byte(rx_byte), .i_byte_ready(byte_ready), .i_spi_busy(spi_busy),
    .o_tx_byte(tx_byte), .o_tx_ready(tx_ready),
    .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata),
    .o_reg_wr_en(reg_wr_en), .o_reg_rd_en(reg_rd_en),
    .i_reg_rdata(reg_rdata), .i_reg_rvalid(reg_rvalid), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus scoreboard: every strobe after an enabled edge pops one expectation.
  always @(posedge clk) en_q <= clk_en;

  always @(negedge clk) begin
    if (rst_n && en_q && (reg_wr_en || reg_rd_en)) begin
      logic [15:0] obs;
      obs = {reg_wr_en, reg_addr, reg_wr_en ? reg_wdata : 8'h00};
      if (bus_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL bus_unexpected observed=%h expected=none", obs);
      end else begin
        check("bus_strobe", obs, bus_q.pop_front());
      end
    end
  end

  // One SS frame: master captures the TX byte, shifts, then spiSlave pulses byte_ready.
  task automatic frame(input logic [7:0] mosi, output logic [7:0] miso);
    miso     = tx_byte;
    spi_busy = 1'b1;
    repeat (7) @(negedge clk);
    rx_byte    = mosi;
    byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
    spi_busy   = 1'b0;
  endtask

  task automatic wait_rd(output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (reg_rd_en) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic rvalid_pulse(input logic [7:0] d);
    reg_rdata  = d;
    reg_rvalid = 1'b1;
    @(negedge clk);
    reg_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_byte"}, 16'(tx_byte), 16'hA5);
    check({tag, "_tx_ready"}, 16'(tx_ready), 16'h1);
    check({tag, "_err"}, 16'(err), 16'h0);
    check({tag, "_strobes"}, 16'({reg_wr_en, reg_rd_en}), 16'h0);
    check({tag, "_addr_wdata"}, 16'({reg_addr, reg_wdata}), 16'h0);
    check({tag, "_state"}, 16'(dut.state), 16'(ST_IDLE));
  endtask

  initial begin
    logic [7:0] miso;
    int k;
    rst_n = 1'b0; clk_en = 1'b1; rx_byte = '0; byte_ready = 1'b0;
    spi_busy = 1'b0; reg_rdata = '0; reg_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write burst 0x12 <- 0x34, 0x56, then gap closes at exactly GAP_CYC idle cycles
    frame(8'h12, miso);
    check("cmd_status_miso", 16'(miso), 16'hA5);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b1, 7'h12, 8'h34});
    frame(8'h34, miso);
    check("wr_latency", 16'(reg_wr_en), 16'h1);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b1, 7'h13, 8'h56});
    frame(8'h56, miso);
    repeat (GAP_CYC) @(negedge clk);
    check("gap_not_yet", 16'(dut.state), 16'(ST_CMD_WR));
    @(negedge clk);
    check("gap_close", 16'(dut.state), 16'(ST_IDLE));
    check("gap_tx", 16'({tx_ready, tx_byte}), 16'h1A5);

    // Read addr 5, rdata 0x9C, then the burst issues addr 6
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b0, 7'h05, 8'h00});
    frame(8'h85, miso);
    wait_rd(k);
    check("rd_latency", 16'(k), 16'd1);
    check("rd_tx_ready_low", 16'(tx_ready), 16'h0);
    repeat (2) @(negedge clk);
    rvalid_pulse(8'h9C);
    check("rvalid_to_tx", 16'({tx_ready, tx_byte}), 16'h19C);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b0, 7'h06, 8'h00});
    frame(8'h00, miso);
    check("rd_miso", 16'(miso), 16'h9C);
    wait_rd(k);
    check("burst_rd_latency", 16'(k), 16'd1);
    rvalid_pulse(8'h11);
    check("burst_rd_tx", 16'({tx_ready, tx_byte}), 16'h111);
    repeat (GAP_CYC + 8) @(negedge clk);
    check("rd_gap_tx", 16'({err, tx_ready, tx_byte}), 16'h1A5);

    // Write burst wrapping past the top address
    frame(8'h7F, miso);
    check("wrap_cmd_miso", 16'(miso), 16'hA5);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b1, 7'h7F, 8'hAA});
    frame(8'hAA, miso);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b1, 7'h00, 8'hBB});
    frame(8'hBB, miso);
    repeat (GAP_CYC + 8) @(negedge clk);

    // Clock enable low for 50 cycles in RD_WAIT; stray rvalid meanwhile is not seen
    bus_q.push_back({1'b0, 7'h0A, 8'h00});
    frame(8'h8A, miso);
    wait_rd(k);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (20) @(negedge clk);
    rvalid_pulse(8'hEE);
    repeat (29) @(negedge clk);
    check("hold_state", 16'(dut.state), 16'(ST_RD_WAIT));
    check("hold_outputs", 16'({err, tx_ready, reg_rd_en, reg_addr}), 16'h00A);
    clk_en = 1'b1;
    repeat (5) @(negedge clk);
    rvalid_pulse(8'h77);
    check("resume_tx", 16'({err, tx_ready, tx_byte}), 16'h177);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b0, 7'h0B, 8'h00});
    frame(8'h00, miso);
    check("resume_miso", 16'(miso), 16'h77);
    wait_rd(k);
    rvalid_pulse(8'h22);
    repeat (GAP_CYC + 8) @(negedge clk);

    // Read timeout: rvalid never comes; err sets on the (RD_LAT_MAX+1)th cycle
    bus_q.push_back({1'b0, 7'h10, 8'h00});
    frame(8'h90, miso);
    wait_rd(k);
    repeat (RD_LAT_MAX) @(negedge clk);
    check("lat_boundary_err", 16'(err), 16'h0);
    @(negedge clk);
    check("lat_timeout_err", 16'(err), 16'h1);
    check("lat_timeout_tx", 16'({tx_ready, tx_byte}), 16'h1FF);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b0, 7'h11, 8'h00});
    frame(8'h00, miso);
    check("timeout_miso", 16'(miso), 16'hFF);
    wait_rd(k);
    rvalid_pulse(8'h33);
    repeat (GAP_CYC + 8) @(negedge clk);
    rvalid_pulse(8'hEE);
    check("idle_rvalid_ignored", 16'({tx_ready, tx_byte}), 16'h1A5);

    // Underrun: data frame starts one cycle after the read command, before rvalid
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst2");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b0, 7'h01, 8'h00});
    frame(8'h81, miso);
    @(negedge clk);
    spi_busy = 1'b1;
    @(negedge clk);
    check("underrun_err", 16'(err), 16'h1);
    rvalid_pulse(8'h5A);
    check("tx_held_busy", 16'({tx_ready, tx_byte}), 16'h0A5);
    repeat (3) @(negedge clk);
    spi_busy = 1'b0;
    @(negedge clk);
    check("tx_release", 16'({tx_ready, tx_byte}), 16'h15A);
    repeat (GAP_CYC + 8) @(negedge clk);

    // Reset asserted in the middle of a write burst
    frame(8'h20, miso);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b1, 7'h20, 8'h01});
    frame(8'h01, miso);
    spi_busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midburst_reset");
    @(negedge clk);
    spi_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame(8'h05, miso);
    repeat (2) @(negedge clk);
    bus_q.push_back({1'b1, 7'h05, 8'h66});
    frame(8'h66, miso);
    check("post_reset_wr", 16'(reg_wr_en), 16'h1);
    repeat (4) @(negedge clk);
    check("bus_drain", 16'(bus_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
